ezm_cpu_gen: RTL
================

# ezm_cpu_gen

Parametrised two-phase accumulator CPU. It is the next generation of the team's 6-bit-instruction accumulator core. It fetches one 6-bit instruction per FETCH cycle from `in_i`, gated by a valid strobe, and executes it in the following EXEC cycle. It adds a configurable data width, register-bank depth and PC width, plus SUB, shift, HALT and status flags. It sits behind the chip-level pin wrapper, which drives `in_i`/`instr_valid` from input pins and presents `out_o` on the output pins.

## Interface
- `DATA_W`, 8: accumulator, bank and `out_o` width; must be ≥ 5.
- `REGS`, 8: register-bank depth, 2..8.
- `PC_W`, 8: program-counter width.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high, clock `clk`.
- `in_i`  in  6  instruction word.
- `instr_valid`  in  1  `in_i` holds a valid instruction; sampled in FETCH only.
- `out_o`  out  DATA_W  in EXEC or HALT: accumulator `c`; in FETCH: `pc`, zero-extended or truncated to DATA_W.
- `zero_o`  out  1  Z flag.
- `carry_o`  out  1  C flag.
- `halted_o`  out  1  core is in HALT.
- `exec_o`  out  1  core is in EXEC.

## Operation
- **State machine:**
  - FETCH → EXEC when `instr_valid`=1. On that edge: latch `in_i` into `ir`, `pc <= pc+1` (mod 2^PC_W).
  - FETCH stays in FETCH when `instr_valid`=0; `pc`, `ir` and all registers are held.
  - EXEC → FETCH after executing `ir`, except the HALT opcode, which goes to HALT.
  - HALT is sticky; only `rst` leaves it.
- **Decode of `ir`** (first match wins):
  - `1iiiii` LDI: `c <= sign-extend(iiiii)` to DATA_W.
  - `011rrr` BGT: if `bank[r] > c` (unsigned), `pc <= pc - c[PC_W-1:0]` (mod 2^PC_W). Otherwise no change.
  - `001rrr` STA: `bank[r] <= c`.
  - `010rrr` ADD: `{C,c} <= c + bank[r]`, with C = carry out of bit DATA_W-1.
  - `0001rr` SUB: `c <= c - bank[rr]`; C = 1 on borrow (`bank[rr] > c` unsigned).
  - `000001` NOT: `c <= ~c`.
  - `000010` SHL: see Configuration.
  - `000011` HALT.
  - `000000` and anything else: NOP.
- **Register index rules:** if index ≥ REGS, reads return 0 and writes are dropped.
- **Flags:**
  - Z <= (new c == 0) on every instruction that writes `c`. Otherwise Z is held.
  - C is written only by ADD, SUB and SHL. Otherwise C is held.
- **Reset values:** `c`, `pc`, `ir`, all bank entries, Z and C = 0; state = FETCH. Consequently `out_o`=0, `halted_o`=0, `exec_o`=0.
- Reset asserted in any state, including mid-EXEC or HALT, wins over everything on that edge.

## Timing
- `out_o`, flags, `halted_o` and `exec_o` are combinational from registers only; no input-to-output path.
- Instruction latency: 2 cycles minimum (FETCH accept plus EXEC). Results are visible on `out_o` during the EXEC cycle only for the previous instruction's `c`; the new `c` is visible in the next EXEC or in HALT.
- `in_i` is don't-care outside a FETCH cycle with `instr_valid`=1.
- BGT offset uses the `pc` value already incremented at FETCH.
- STA followed immediately by ADD on the same register reads the newly stored value, since they are in different cycles.

## Configuration
- Macro `EZM_CPU_SHIFT_EN`.
- **Defined:** `000010` executes SHL: `C <= c[DATA_W-1]`, `c <= c << 1`, Z updated.
- **Undefined:** `000010` is a NOP; `c`, Z and C are unchanged. No shifter logic is synthesised.

## Test plan
- **Reset plus LDI:** reset, then LDI `110011` (imm -13) → in EXEC of the next instruction, `out_o`=0xF3, Z=0; `pc` reads 1 in the following FETCH, then 2.
- **ADD carry:** LDI -1 (`111111`), STA r2, LDI 1, ADD r2 → c=0x00, Z=1, C=1.
- **SUB borrow:** LDI 3, STA r1, LDI 1, SUB r1 → c=0xFE, C=1, Z=0.
- **BGT loop:** LDI 2, STA r0, LDI 1, BGT r0 → `pc` goes 4 → 3. With `bank[0]`=1, the same BGT leaves `pc`=4.
- **Stall, halt and reset:**
  - `instr_valid`=0 for 5 cycles in FETCH → `pc` and `out_o` constant.
  - HALT → `halted_o`=1; further `in_i` and `instr_valid` are ignored.
  - `rst` → all outputs 0.
- **SHL:** LDI -16 then SHL → with `EZM_CPU_SHIFT_EN`: c=0xE0, C=1. Without the macro: c=0xF0, C unchanged. Also check a write to r7 with REGS=4: it is dropped and reads return 0.

Source files
------------

// File: rtl/ezm_cpu_gen.sv
// Two-phase (FETCH/EXEC) accumulator CPU with a small register bank, Z/C flags and HALT.
// Optional shift-left instruction enabled by defining EZM_CPU_SHIFT_EN.
module ezm_cpu_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REGS   = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        in_i,
    input  logic              instr_valid,
    output logic [DATA_W-1:0] out_o,
    output logic              zero_o,
    output logic              carry_o,
    output logic              halted_o,
    output logic              exec_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n;
    logic [5:0]        ir, ir_n;
    logic [DATA_W-1:0] c, c_n;
    logic              z, z_n;
    logic              cy, cy_n;
    logic              c_wr;
    logic [DATA_W-1:0] bank   [REGS];
    logic [DATA_W-1:0] bank_n [REGS];

    logic [2:0]        idx;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W:0]   sum;

    // Bank read port; SUB carries a 2-bit index, out-of-range indices read as zero
    always_comb begin
        idx    = (ir[5:2] == 4'b0001) ? {1'b0, ir[1:0]} : ir[2:0];
        rd_val = '0;
        for (int unsigned i = 0; i < REGS; i++) begin
            if (idx == 3'(i)) rd_val = bank[i];
        end
    end

    // Next-state, datapath and flag update
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        c_n     = c;
        z_n     = z;
        cy_n    = cy;
        c_wr    = 1'b0;
        bank_n  = bank;
        sum     = '0;

        unique case (state)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_n    = in_i;
                    pc_n    = pc + PC_W'(1);
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                casez (ir)
                    6'b1?????: begin
                        c_n  = {{(DATA_W-5){ir[4]}}, ir[4:0]};
                        c_wr = 1'b1;
                    end
                    6'b011???: begin
                        if (rd_val > c) pc_n = pc - PC_W'(c);
                    end
                    6'b001???: begin
                        for (int unsigned i = 0; i < REGS; i++) begin
                            if (ir[2:0] == 3'(i)) bank_n[i] = c;
                        end
                    end
                    6'b010???: begin
                        sum  = {1'b0, c} + {1'b0, rd_val};
                        c_n  = sum[DATA_W-1:0];
                        cy_n = sum[DATA_W];
                        c_wr = 1'b1;
                    end
                    6'b0001??: begin
                        c_n  = c - rd_val;
                        cy_n = (rd_val > c);
                        c_wr = 1'b1;
                    end
                    6'b000001: begin
                        c_n  = ~c;
                        c_wr = 1'b1;
                    end
                    6'b000010: begin
`ifdef EZM_CPU_SHIFT_EN
                        cy_n = c[DATA_W-1];
                        c_n  = {c[DATA_W-2:0], 1'b0};
                        c_wr = 1'b1;
`else
                        c_wr = 1'b0;
`endif
                    end
                    6'b000011: state_n = S_HALT;
                    default: ;
                endcase
                if (c_wr) z_n = (c_n == '0);
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            c     <= '0;
            z     <= 1'b0;
            cy    <= 1'b0;
            for (int unsigned i = 0; i < REGS; i++) bank[i] <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            c     <= c_n;
            z     <= z_n;
            cy    <= cy_n;
            for (int unsigned i = 0; i < REGS; i++) bank[i] <= bank_n[i];
        end
    end

    // FETCH shows the program counter, all other phases show the accumulator
    assign out_o    = (state == S_FETCH) ? DATA_W'(pc) : c;
    assign zero_o   = z;
    assign carry_o  = cy;
    assign halted_o = (state == S_HALT);
    assign exec_o   = (state == S_EXEC);

endmodule
